// File: rtl/nfc_sfr_bank.sv
// NAND-flash-controller SFR bank: byte-wide register file between the MIF bus
// and the NFC engine, with command FIFO, RnB synchroniser, W1C interrupts and config lock.
module nfc_sfr_bank #(
  parameter int NUM_CE     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SEED_BYTES = 4
) (
  input  logic                    nfc_clk,
  input  logic                    rstb_nfc,
  input  logic                    mif_nfc_reg_wr,
  input  logic                    mif_nfc_reg_rd,
  input  logic [8:0]              mif_nfc_reg_addr,
  input  logic [7:0]              mif_nfc_reg_din,
  output logic [7:0]              nfc_mif_reg_dout,
  input  logic                    rnb_i,
  input  logic                    nf_busy,
  input  logic                    addr_clear,
  input  logic                    data_clear,
  input  logic                    cmd_done,
  input  logic                    ecc_err,
  output logic [7:0]              nf_cmd,
  output logic                    nf_cmd_valid,
  input  logic                    nf_cmd_ready,
  output logic [7:0]              nf_ctrl0,
  output logic [1:0]              nf_ecc_ctrl,
  output logic [NUM_CE-1:0]       nf_ceb,
  output logic [7:0]              nf_timing,
  output logic [15:0]             nf_trn_cnt,
  output logic [31:0]             nf_column_addr,
  output logic [31:0]             nf_row_addr,
  output logic [8*SEED_BYTES-1:0] nf_rand_seed,
  output logic                    nf_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [NUM_CE-1:0] CEB_RST = ~NUM_CE'(1);

  localparam logic [5:0] A_ECC    = 6'h00;
  localparam logic [5:0] A_CMD    = 6'h10;
  localparam logic [5:0] A_CTRL0  = 6'h11;
  localparam logic [5:0] A_CE     = 6'h12;
  localparam logic [5:0] A_STAT   = 6'h13;
  localparam logic [5:0] A_MASK   = 6'h14;
  localparam logic [5:0] A_TIMING = 6'h15;
  localparam logic [5:0] A_ROW3   = 6'h1F;

  logic             sel;
  logic [5:0]       off;
  logic             wr_en;
  logic             seed_hit;
  logic             lockable;
  logic             lock_hit;
  logic             wr_cfg;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             ovf;

  logic             rnb_p0;
  logic             rnb_p1;
  logic             rnb_p2;
  logic             rnb_rise;
  logic [4:0]       int_status;
  logic [4:0]       int_mask;
  logic [4:0]       stat_set;
  logic [4:0]       stat_clr;
  logic [7:0]       rd_data;

  function automatic logic [3:0] sat_level(input logic [CNT_W-1:0] c);
    logic [4:0] c5;
    c5 = 5'(c);
    return (c5 > 5'd15) ? 4'hF : c5[3:0];
  endfunction

  assign sel      = (mif_nfc_reg_addr[8:6] == 3'b000);
  assign off      = mif_nfc_reg_addr[5:0];
  assign wr_en    = mif_nfc_reg_wr & sel;
  assign seed_hit = (int'(off) >= 32) && (int'(off) < 32 + SEED_BYTES);
  assign lockable = ((off >= A_TIMING) && (off <= A_ROW3)) || seed_hit;
  assign lock_hit = wr_en & nf_busy & lockable;
  assign wr_cfg   = wr_en & ~nf_busy;

  // Command FIFO: a push into a full FIFO is still accepted when the head pops that cycle
  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign nf_cmd_valid = (count != '0);
  assign pop          = nf_cmd_valid & nf_cmd_ready;
  assign push_req     = wr_en & (off == A_CMD);
  assign push         = push_req & (~full | pop);
  assign ovf          = push_req & full & ~pop;
  assign nf_cmd       = nf_cmd_valid ? mem[rptr] : 8'h00;

  always_ff @(posedge nfc_clk) begin
    if (push) mem[wptr] <= mif_nfc_reg_din;
  end

  always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
    if (!rstb_nfc) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // RnB synchroniser: p0/p1 resynchronise, p2 holds the previous synced value for edge detect
  always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
    if (!rstb_nfc) begin
      rnb_p0 <= 1'b0;
      rnb_p1 <= 1'b0;
      rnb_p2 <= 1'b0;
    end else begin
      rnb_p0 <= rnb_i;
      rnb_p1 <= rnb_p0;
      rnb_p2 <= rnb_p1;
    end
  end

  assign rnb_rise = rnb_p1 & ~rnb_p2;
  assign stat_set = {ecc_err, lock_hit, ovf, cmd_done, rnb_rise};
  assign stat_clr = (wr_en && (off == A_STAT)) ? mif_nfc_reg_din[4:0] : 5'b0;

  always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
    if (!rstb_nfc) begin
      int_status <= '0;
      nf_irq     <= 1'b0;
    end else begin
      int_status <= (int_status & ~stat_clr) | stat_set;
      nf_irq     <= |(int_status & int_mask);
    end
  end

  always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
    if (!rstb_nfc) begin
      nf_ecc_ctrl    <= '0;
      nf_ctrl0       <= '0;
      nf_ceb         <= CEB_RST;
      int_mask       <= '0;
      nf_timing      <= '0;
      nf_trn_cnt     <= '0;
      nf_column_addr <= '0;
      nf_row_addr    <= '0;
      nf_rand_seed   <= '1;
    end else begin
      if (wr_en && (off == A_ECC))  nf_ecc_ctrl <= mif_nfc_reg_din[1:0];
      if (wr_en && (off == A_CE))   nf_ceb      <= mif_nfc_reg_din[NUM_CE-1:0];
      if (wr_en && (off == A_MASK)) int_mask    <= mif_nfc_reg_din[4:0];
      // A CPU write overrides the engine-side clear pulses
      if (wr_en && (off == A_CTRL0)) begin
        nf_ctrl0 <= mif_nfc_reg_din;
      end else begin
        if (addr_clear) nf_ctrl0[1] <= 1'b0;
        if (data_clear) nf_ctrl0[0] <= 1'b0;
      end
      if (wr_cfg) begin
        case (off)
          A_TIMING: nf_timing             <= mif_nfc_reg_din;
          6'h16:    nf_trn_cnt[7:0]       <= mif_nfc_reg_din;
          6'h17:    nf_trn_cnt[15:8]      <= mif_nfc_reg_din;
          6'h18:    nf_column_addr[7:0]   <= mif_nfc_reg_din;
          6'h19:    nf_column_addr[15:8]  <= mif_nfc_reg_din;
          6'h1A:    nf_column_addr[23:16] <= mif_nfc_reg_din;
          6'h1B:    nf_column_addr[31:24] <= mif_nfc_reg_din;
          6'h1C:    nf_row_addr[7:0]      <= mif_nfc_reg_din;
          6'h1D:    nf_row_addr[15:8]     <= mif_nfc_reg_din;
          6'h1E:    nf_row_addr[23:16]    <= mif_nfc_reg_din;
          6'h1F:    nf_row_addr[31:24]    <= mif_nfc_reg_din;
          default:  ;
        endcase
        for (int i = 0; i < SEED_BYTES; i++) begin
          if (int'(off) == 32 + i) nf_rand_seed[8*i +: 8] <= mif_nfc_reg_din;
        end
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (sel) begin
      case (off)
        A_ECC:    rd_data = {6'b0, nf_ecc_ctrl};
        A_CMD:    rd_data = {4'b0, sat_level(count)};
        A_CTRL0:  rd_data = nf_ctrl0;
        A_CE:     rd_data[NUM_CE-1:0] = nf_ceb;
        A_STAT:   rd_data = {rnb_p1, 2'b00, int_status};
        A_MASK:   rd_data = {3'b0, int_mask};
        A_TIMING: rd_data = nf_timing;
        6'h16:    rd_data = nf_trn_cnt[7:0];
        6'h17:    rd_data = nf_trn_cnt[15:8];
        6'h18:    rd_data = nf_column_addr[7:0];
        6'h19:    rd_data = nf_column_addr[15:8];
        6'h1A:    rd_data = nf_column_addr[23:16];
        6'h1B:    rd_data = nf_column_addr[31:24];
        6'h1C:    rd_data = nf_row_addr[7:0];
        6'h1D:    rd_data = nf_row_addr[15:8];
        6'h1E:    rd_data = nf_row_addr[23:16];
        6'h1F:    rd_data = nf_row_addr[31:24];
        default: begin
          for (int i = 0; i < SEED_BYTES; i++) begin
            if (int'(off) == 32 + i) rd_data = nf_rand_seed[8*i +: 8];
          end
        end
      endcase
    end
  end

  // Read data stage: captured on rd, held until the next rd
  always_ff @(posedge nfc_clk or negedge rstb_nfc) begin
    if (!rstb_nfc)           nfc_mif_reg_dout <= 8'h00;
    else if (mif_nfc_reg_rd) nfc_mif_reg_dout <= rd_data;
  end

endmodule

// File: tb/tb_nfc_sfr_bank.sv
// Bench for nfc_sfr_bank: directed scenarios plus random traffic against a
// register-map model; read data and FIFO pops are checked by a negedge monitor.
`timescale 1ns/1ps
module tb_nfc_sfr_bank;
  localparam int NUM_CE = 4;
  localparam int DEPTH  = 4;
  localparam int SB     = 4;

  logic        nfc_clk = 1'b0;
  logic        rstb_nfc = 1'b0;
  logic        mif_nfc_reg_wr = 1'b0;
  logic        mif_nfc_reg_rd = 1'b0;
  logic [8:0]  mif_nfc_reg_addr = '0;
  logic [7:0]  mif_nfc_reg_din = '0;
  logic        rnb_i = 1'b0;
  logic        nf_busy = 1'b0;
  logic        addr_clear = 1'b0;
  logic        data_clear = 1'b0;
  logic        cmd_done = 1'b0;
  logic        ecc_err = 1'b0;
  logic        nf_cmd_ready = 1'b0;

  logic [7:0]  nfc_mif_reg_dout, nf_cmd, nf_ctrl0, nf_timing;
  logic        nf_cmd_valid, nf_irq;
  logic [1:0]  nf_ecc_ctrl;
  logic [3:0]  nf_ceb;
  logic [15:0] nf_trn_cnt;
  logic [31:0] nf_column_addr, nf_row_addr, nf_rand_seed;

  logic [7:0]  dout2, cmd2, ctrl0_2, timing2;
  logic        cmd_valid2, irq2;
  logic [1:0]  ecc2;
  logic [3:0]  ceb2;
  logic [15:0] trn2, seed2;
  logic [31:0] col2, row2;

  always #5 nfc_clk = ~nfc_clk;

  nfc_sfr_bank #(.NUM_CE(NUM_CE), .FIFO_DEPTH(DEPTH), .SEED_BYTES(SB)) u_dut (
    .nfc_clk(nfc_clk), .rstb_nfc(rstb_nfc),
    .mif_nfc_reg_wr(mif_nfc_reg_wr), .mif_nfc_reg_rd(mif_nfc_reg_rd),
    .mif_nfc_reg_addr(mif_nfc_reg_addr), .mif_nfc_reg_din(mif_nfc_reg_din),
    .nfc_mif_reg_dout(nfc_mif_reg_dout), .rnb_i(rnb_i), .nf_busy(nf_busy),
    .addr_clear(addr_clear), .data_clear(data_clear), .cmd_done(cmd_done),
    .ecc_err(ecc_err), .nf_cmd(nf_cmd), .nf_cmd_valid(nf_cmd_valid),
    .nf_cmd_ready(nf_cmd_ready), .nf_ctrl0(nf_ctrl0), .nf_ecc_ctrl(nf_ecc_ctrl),
    .nf_ceb(nf_ceb), .nf_timing(nf_timing), .nf_trn_cnt(nf_trn_cnt),
    .nf_column_addr(nf_column_addr), .nf_row_addr(nf_row_addr),
    .nf_rand_seed(nf_rand_seed), .nf_irq(nf_irq));

  nfc_sfr_bank #(.NUM_CE(NUM_CE), .FIFO_DEPTH(DEPTH), .SEED_BYTES(2)) u_dut2 (
    .nfc_clk(nfc_clk), .rstb_nfc(rstb_nfc),
    .mif_nfc_reg_wr(mif_nfc_reg_wr), .mif_nfc_reg_rd(mif_nfc_reg_rd),
    .mif_nfc_reg_addr(mif_nfc_reg_addr), .mif_nfc_reg_din(mif_nfc_reg_din),
    .nfc_mif_reg_dout(dout2), .rnb_i(rnb_i), .nf_busy(nf_busy),
    .addr_clear(addr_clear), .data_clear(data_clear), .cmd_done(cmd_done),
    .ecc_err(ecc_err), .nf_cmd(cmd2), .nf_cmd_valid(cmd_valid2),
    .nf_cmd_ready(nf_cmd_ready), .nf_ctrl0(ctrl0_2), .nf_ecc_ctrl(ecc2),
    .nf_ceb(ceb2), .nf_timing(timing2), .nf_trn_cnt(trn2),
    .nf_column_addr(col2), .nf_row_addr(row2),
    .nf_rand_seed(seed2), .nf_irq(irq2));

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] m_reg [64];
  logic [4:0] m_stat;
  logic       m_irq;
  logic       h0, h1, h2;
  logic [7:0] m_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] exp_cmd_q[$];
  logic       lv_busy = 1'b0, lv_rdy = 1'b0, lv_rnb = 1'b0;
  logic       rd_cap = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_seed(input logic [5:0] o);
    return (int'(o) >= 32) && (int'(o) < 32 + SB);
  endfunction
  function automatic bit m_lockable(input logic [5:0] o);
    return ((o >= 6'h15) && (o <= 6'h1F)) || m_seed(o);
  endfunction
  function automatic bit m_mapped(input logic [5:0] o);
    return (o == 6'h00) || (o == 6'h11) || (o == 6'h12) || (o == 6'h14) || m_lockable(o);
  endfunction
  function automatic logic [7:0] m_wmask(input logic [5:0] o);
    case (o)
      6'h00:   return 8'h03;
      6'h12:   return 8'h0F;
      6'h14:   return 8'h1F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input logic [8:0] a);
    int lvl;
    if (a[8:6] != 3'b000) return 8'h00;
    if (a[5:0] == 6'h10) begin
      lvl = m_q.size();
      if (lvl > 15) lvl = 15;
      return 8'(lvl);
    end
    if (a[5:0] == 6'h13) return {h1, 2'b00, m_stat};
    if (m_mapped(a[5:0])) return m_reg[a[5:0]];
    return 8'h00;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_reg[6'h12] = 8'h0E;
    for (int i = 0; i < SB; i++) m_reg[32 + i] = 8'hFF;
    m_stat = '0;
    m_irq  = 1'b0;
    h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    m_q.delete();
    exp_rd_q.delete();
    exp_cmd_q.delete();
  endtask

  // One bus cycle: drive, advance the model across the edge, compare outputs
  task automatic step(input logic wr, input logic rd, input logic [8:0] a, input logic [7:0] d,
                      input logic acl, input logic dcl, input logic cdone, input logic eerr);
    logic [5:0] o;
    logic       hit, pop, push_req, acc;
    logic [4:0] set, clr;
    int         sz;
    mif_nfc_reg_wr = wr; mif_nfc_reg_rd = rd; mif_nfc_reg_addr = a; mif_nfc_reg_din = d;
    addr_clear = acl; data_clear = dcl; cmd_done = cdone; ecc_err = eerr;
    nf_busy = lv_busy; nf_cmd_ready = lv_rdy; rnb_i = lv_rnb;
    if (rd) exp_rd_q.push_back(m_read(a));
    @(posedge nfc_clk);
    o        = a[5:0];
    hit      = wr && (a[8:6] == 3'b000);
    sz       = m_q.size();
    pop      = (sz > 0) && lv_rdy;
    push_req = hit && (o == 6'h10);
    acc      = push_req && ((sz < DEPTH) || pop);
    set      = {eerr, hit && lv_busy && m_lockable(o), push_req && !acc, cdone, h1 && !h2};
    clr      = (hit && (o == 6'h13)) ? d[4:0] : 5'b0;
    m_irq    = |(m_stat & m_reg[6'h14][4:0]);
    m_stat   = (m_stat & ~clr) | set;
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(d);
      exp_cmd_q.push_back(d);
    end
    if (hit && (o == 6'h11)) m_reg[6'h11] = d;
    else begin
      if (acl) m_reg[6'h11][1] = 1'b0;
      if (dcl) m_reg[6'h11][0] = 1'b0;
    end
    if (hit && m_mapped(o) && (o != 6'h11) && !(lv_busy && m_lockable(o)))
      m_reg[o] = d & m_wmask(o);
    h2 = h1; h1 = h0; h0 = lv_rnb;
    #1;
    mif_nfc_reg_wr = 1'b0; mif_nfc_reg_rd = 1'b0;
    addr_clear = 1'b0; data_clear = 1'b0; cmd_done = 1'b0; ecc_err = 1'b0;
    chk("irq", nf_irq, m_irq);
    chk("cmd_valid", nf_cmd_valid, m_q.size() != 0);
    chk("cmd_head", nf_cmd, (m_q.size() != 0) ? m_q[0] : 8'h00);
    chk("ctrl0", nf_ctrl0, m_reg[6'h11]);
    chk("ecc_ctrl", nf_ecc_ctrl, m_reg[6'h00][1:0]);
    chk("ceb", nf_ceb, m_reg[6'h12][3:0]);
    chk("timing", nf_timing, m_reg[6'h15]);
    chk("trn_cnt", nf_trn_cnt, {m_reg[6'h17], m_reg[6'h16]});
    chk("column", nf_column_addr, {m_reg[6'h1B], m_reg[6'h1A], m_reg[6'h19], m_reg[6'h18]});
    chk("row", nf_row_addr, {m_reg[6'h1F], m_reg[6'h1E], m_reg[6'h1D], m_reg[6'h1C]});
    chk("seed", nf_rand_seed, {m_reg[6'h23], m_reg[6'h22], m_reg[6'h21], m_reg[6'h20]});
  endtask

  task automatic wr_reg(input logic [8:0] a, input logic [7:0] d);
    step(1'b1, 1'b0, a, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic rd_reg(input logic [8:0] a);
    step(1'b0, 1'b1, a, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [8:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return 9'h000;
      1:       return 9'h010;
      2:       return 9'h013;
      3:       return 9'h014;
      4, 5:    return 9'h010 + 9'($urandom_range(0, 15));
      6:       return 9'h020 + 9'($urandom_range(0, 5));
      7:       return {3'($urandom_range(1, 7)), 6'($urandom_range(0, 63))};
      8:       return {3'b000, 6'($urandom_range(0, 63))};
      default: return 9'h011;
    endcase
  endfunction

  always @(posedge nfc_clk or negedge rstb_nfc) begin
    if (!rstb_nfc) rd_cap <= 1'b0;
    else           rd_cap <= mif_nfc_reg_rd;
  end

  // Monitor: read responses and engine pops against their expected queues
  always @(negedge nfc_clk) begin
    if (rstb_nfc) begin
      if (rd_cap) begin
        if (exp_rd_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rd_data: got %0h with no read outstanding", nfc_mif_reg_dout);
        end else chk("rd_data", nfc_mif_reg_dout, exp_rd_q.pop_front());
      end
      if (nf_cmd_valid && nf_cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL cmd_pop: got %0h with nothing queued", nf_cmd);
        end else chk("cmd_pop", nf_cmd, exp_cmd_q.pop_front());
      end
    end
  end

  initial begin
    logic [8:0] a;
    int         op;
    m_reset();
    repeat (3) @(posedge nfc_clk);
    #1;
    chk("rst_ceb", nf_ceb, 4'b1110);
    chk("rst_seed", nf_rand_seed, 32'hFFFF_FFFF);
    chk("rst_seed2", seed2, 16'hFFFF);
    chk("rst_irq", nf_irq, 1'b0);
    chk("rst_valid", nf_cmd_valid, 1'b0);
    chk("rst_cmd", nf_cmd, 8'h00);
    chk("rst_dout", nfc_mif_reg_dout, 8'h00);
    rstb_nfc = 1'b1;

    rd_reg(9'h012);
    chk("ce_read", nfc_mif_reg_dout, 8'h0E);

    lv_rdy = 1'b0;
    wr_reg(9'h010, 8'h00); wr_reg(9'h010, 8'h30); wr_reg(9'h010, 8'h70);
    wr_reg(9'h010, 8'h90); wr_reg(9'h010, 8'hFF);
    rd_reg(9'h010);
    chk("fifo_level", nfc_mif_reg_dout, 8'h04);
    rd_reg(9'h013);
    chk("ovf_status", nfc_mif_reg_dout, 8'h04);
    lv_rdy = 1'b1;
    idle(5);
    chk("valid_drop", nf_cmd_valid, 1'b0);

    wr_reg(9'h013, 8'hFF);
    lv_busy = 1'b1;
    wr_reg(9'h016, 8'h55);
    chk("trn_locked", nf_trn_cnt, 16'h0000);
    rd_reg(9'h013);
    chk("lock_status", nfc_mif_reg_dout, 8'h08);
    wr_reg(9'h014, 8'h08);
    idle(1);
    chk("irq_hi", nf_irq, 1'b1);
    wr_reg(9'h013, 8'h08);
    idle(1);
    chk("irq_lo", nf_irq, 1'b0);
    lv_busy = 1'b0;

    lv_rnb = 1'b1;
    idle(3);
    rd_reg(9'h013);
    chk("rnb_rise", nfc_mif_reg_dout, 8'h81);
    lv_rnb = 1'b0;
    idle(3);
    wr_reg(9'h013, 8'h01);
    lv_rnb = 1'b1;
    idle(2);
    wr_reg(9'h013, 8'h01);
    rd_reg(9'h013);
    chk("rnb_w1c_race", nfc_mif_reg_dout, 8'h81);

    step(1'b1, 1'b0, 9'h011, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ctrl0_wr_wins", nf_ctrl0, 8'h03);
    step(1'b0, 1'b0, 9'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ctrl0_dclr", nf_ctrl0, 8'h02);

    wr_reg(9'h020, 8'h12); wr_reg(9'h021, 8'h34); wr_reg(9'h022, 8'hAA);
    rd_reg(9'h022);
    chk("seed2_unmapped_rd", dout2, 8'h00);
    chk("seed2_value", seed2, 16'h3412);
    chk("seed4_byte2", nf_rand_seed[23:16], 8'hAA);

    for (int i = 0; i < 600; i++) begin
      lv_busy = ($urandom_range(0, 3) == 0);
      lv_rdy  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) lv_rnb = ~lv_rnb;
      a  = pick_addr();
      op = $urandom_range(0, 3);
      step(op == 0 || op == 2, op == 1 || op == 2, a, 8'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    lv_busy = 1'b0; lv_rdy = 1'b0;
    wr_reg(9'h010, 8'hA1); wr_reg(9'h010, 8'hB2); wr_reg(9'h015, 8'h5A);
    idle(1);
    #2 rstb_nfc = 1'b0;
    #1;
    chk("arst_valid", nf_cmd_valid, 1'b0);
    chk("arst_ceb", nf_ceb, 4'b1110);
    chk("arst_timing", nf_timing, 8'h00);
    chk("arst_seed", nf_rand_seed, 32'hFFFF_FFFF);
    chk("arst_irq", nf_irq, 1'b0);
    chk("arst_dout", nfc_mif_reg_dout, 8'h00);
    m_reset();
    @(posedge nfc_clk);
    #1 rstb_nfc = 1'b1;
    lv_rdy = 1'b1;
    wr_reg(9'h010, 8'h3C);
    rd_reg(9'h010);
    idle(6);
    @(negedge nfc_clk);
    #1;
    chk("rd_q_drained", exp_rd_q.size(), 0);
    chk("cmd_q_drained", exp_cmd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
